regfile_write_queue: RTL and testbench
======================================

// Module: regfile_write_queue
// PURPOSE
//  Write-side feeder for the 8-entry register file (r0..r7, one write port).
//  Accepts (addr, data) write-back results from execution units over a valid/ready
//  handshake and buffers them in a DEPTH-entry FIFO.
//  Drains the FIFO one entry per cycle into the register file write port (write/waddr/wdata).
//  Exposes a combinational lookup so decode can forward values still queued.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of two, >= 2
//  AW     5   register address width (file decodes only addr[2:0])
//  DW     32  data width
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      synchronous, active-low reset (sampled on rising clock)
//  in_valid  in   1      producer has a write-back result
//  in_ready  out  1      queue can accept this cycle
//  in_addr   in   AW     destination register
//  in_data   in   DW     result value
//  wr_hold   in   1      register file port busy; suppress drain this cycle
//  write     out  1      to register file: write enable
//  waddr     out  AW     to register file: write address
//  wdata     out  DW     to register file: write data
//  q_addr    in   AW     forwarding lookup address
//  q_hit     out  1      a queued entry targets q_addr[2:0]
//  q_data    out  DW     data of youngest matching queued entry
//  count     out  log2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - State: storage[DEPTH], rd_ptr, wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH), count.
//  - reset==0 at an edge: rd_ptr=wr_ptr=0, count=0; queued entries dropped (storage unchanged).
//    Any push/pop that cycle is ignored.
//  - Values after reset: in_ready=1, write=0, waddr=0, wdata=0, q_hit=0, q_data=0, count=0.
//  - in_ready = (count != DEPTH). Depends on registered state only; no path from wr_hold or in_valid.
//  - push = in_valid & in_ready. Stores {in_addr,in_data} at wr_ptr; wr_ptr+1.
//  - write = (count != 0) & ~wr_hold.
//    waddr/wdata = head entry when count != 0, else 0.
//    Under wr_hold, waddr/wdata still show the head entry.
//  - pop = write. On the edge, rd_ptr+1.
//    The register file captures the same edge, so the entry is retired.
//  - count next = count + push - pop; simultaneous push & pop leaves count unchanged.
//  - Full (count==DEPTH): in_ready=0, even if a pop happens that cycle. Producer retries next cycle.
//  - Empty: write=0; an entry pushed at edge k is written no earlier than edge k+1.
//    No same-cycle bypass from in_* to write.
//  - Order: strict FIFO. Duplicate addresses are all written, in order; the last one wins in the file.
//  - Lookup (combinational):
//    - Compares addr[2:0] of every occupied entry against q_addr[2:0]. Upper address bits are ignored.
//    - q_hit=1 if any match. q_data = youngest match (closest to wr_ptr), else 0.
//    - The head entry being popped this cycle still counts as a hit.
//    - in_* of the current cycle is never included.
//  - in_addr is not filtered: r0 writes are queued and written like any other register.
// TESTING
//  1 reset=0 one cycle -> count=0, in_ready=1, write=0, q_hit=0; then push (3,0xA5) -> next cycle write=1, waddr=3, wdata=0xA5; following cycle count=0.
//  2 wr_hold=1, push (1,0x11),(2,0x22),(3,0x33),(4,0x44) -> count=4, in_ready=0, write=0; 5th push stalls; release hold -> writes 1,2,3,4 on 4 consecutive edges.
//  3 hold=1, queue (5,0x1),(13,0x2) -> q_addr=5 gives q_hit=1, q_data=0x2 (13[2:0]=5, youngest wins); q_addr=6 gives q_hit=0.
//  4 count=2, hold=0, continuous valid -> push and pop each edge; count stays 2; ptr wrap past DEPTH preserves order over 10 entries.
//  5 queue 3 entries under hold, then reset=0 -> next cycle count=0, write=0, q_hit=0; subsequent push (7,0x77) -> written alone.

Source files
------------

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: buffers (addr, data) write-back results in a small FIFO
// and drains them one per cycle into the register file write port. A
// combinational lookup lets decode forward values that are still queued.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       wr_hold,
  output logic                       write,
  output logic [AW-1:0]              waddr,
  output logic [DW-1:0]              wdata,
  input  logic [AW-1:0]              q_addr,
  output logic                       q_hit,
  output logic [DW-1:0]              q_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] addrStore_q [DEPTH];
  logic [DW-1:0] dataStore_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic notEmpty;
  logic unusedQAddr;

  // The register file decodes only the low three address bits, so the lookup
  // does the same; the upper bits are deliberately ignored.
  assign unusedQAddr = ^q_addr;

  assign notEmpty = (count_q != '0);
  // in_ready looks only at registered occupancy: a full queue refuses even
  // when a pop is happening, which keeps wr_hold/in_valid off this path.
  assign in_ready = (count_q != FULL);
  assign push     = in_valid & in_ready;
  assign write    = notEmpty & ~wr_hold;
  assign pop      = write;
  assign count    = count_q;

  // Head entry is presented to the register file even while held off.
  always_comb begin
    waddr = '0;
    wdata = '0;
    if (notEmpty) begin
      waddr = addrStore_q[rdPtr_q];
      wdata = dataStore_q[rdPtr_q];
    end
  end

  // Pointer and occupancy next-state; simultaneous push and pop cancel out.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the queue and drops any
  // push or pop presented in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are left alone by reset since occupancy guards them.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      addrStore_q[wrPtr_q] <= in_addr;
      dataStore_q[wrPtr_q] <= in_data;
    end
  end

  // Forwarding lookup: walk occupied entries oldest to youngest so the
  // youngest match is the one left standing.
  always_comb begin
    logic [PW-1:0] idx;
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr_q + PW'(i);
      if ((CW'(i) < count_q) && (addrStore_q[idx][2:0] == q_addr[2:0])) begin
        q_hit  = 1'b1;
        q_data = dataStore_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed scenarios for the register-file write queue.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          wr_hold;
  logic          write;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] q_addr;
  logic          q_hit;
  logic [DW-1:0] q_data;
  logic [2:0]    count;

  int testsRun;
  int testsFailed;

  regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .wr_hold  (wr_hold),
    .write    (write),
    .waddr    (waddr),
    .wdata    (wdata),
    .q_addr   (q_addr),
    .q_hit    (q_hit),
    .q_data   (q_data),
    .count    (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; wr_hold = 1'b0; q_addr = 5'd0;
    tick();
    reset = 1'b1;
    #1;
    testsRun++; if (count !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    testsRun++; if (write !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_write got %b want 0", write); end
    testsRun++; if (q_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_q_hit got %b want 0", q_hit); end
    testsRun++; if (waddr !== 5'd0 || wdata !== 32'd0 || q_data !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_zero_outputs got waddr=%0d wdata=%h q_data=%h want 0/0/0", waddr, wdata, q_data); end
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'hA5;
    #1;
    testsRun++; if (write !== 1'b0) begin testsFailed++; $display("[TB] FAIL no_bypass got write=%b want 0", write); end
    tick();
    in_valid = 1'b0; q_addr = 5'd3;
    #1;
    testsRun++; if (write !== 1'b1 || waddr !== 5'd3 || wdata !== 32'hA5) begin testsFailed++; $display("[TB] FAIL single_write got %b/%0d/%h want 1/3/a5", write, waddr, wdata); end
    testsRun++; if (q_hit !== 1'b1 || q_data !== 32'hA5) begin testsFailed++; $display("[TB] FAIL single_lookup got %b/%h want 1/a5", q_hit, q_data); end
    tick();
    testsRun++; if (count !== 3'd0 || write !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_drained got count=%0d write=%b want 0/0", count, write); end
  endtask

  task automatic test_full_hold();
    wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = AW'(i); in_data = 32'h11 * i;
      tick();
    end
    testsRun++; if (count !== 3'd4 || in_ready !== 1'b0 || write !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_state got count=%0d in_ready=%b write=%b want 4/0/0", count, in_ready, write); end
    testsRun++; if (waddr !== 5'd1 || wdata !== 32'h11) begin testsFailed++; $display("[TB] FAIL hold_head_visible got %0d/%h want 1/11", waddr, wdata); end
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'h55;
    tick();
    testsRun++; if (count !== 3'd4) begin testsFailed++; $display("[TB] FAIL fifth_push_stall got count=%0d want 4", count); end
    wr_hold = 1'b0;
    #1;
    testsRun++; if (in_ready !== 1'b0 || write !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_with_pop got in_ready=%b write=%b want 0/1", in_ready, write); end
    tick();
    in_valid = 1'b0;
    #1;
    testsRun++; if (count !== 3'd3) begin testsFailed++; $display("[TB] FAIL retry_blocked got count=%0d want 3", count); end
    for (int k = 2; k <= 4; k++) begin
      testsRun++; if (write !== 1'b1 || waddr !== AW'(k) || wdata !== 32'h11 * k) begin testsFailed++; $display("[TB] FAIL drain_%0d got %b/%0d/%h want 1/%0d/%h", k, write, waddr, wdata, k, 32'h11 * k); end
      tick();
    end
    testsRun++; if (count !== 3'd0 || write !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_empty got count=%0d write=%b want 0/0", count, write); end
  endtask

  task automatic test_lookup();
    wr_hold = 1'b1;
    in_valid = 1'b1; in_addr = 5'd5;  in_data = 32'h1; tick();
    in_valid = 1'b1; in_addr = 5'd13; in_data = 32'h2; tick();
    in_valid = 1'b0; in_addr = 5'd6; in_data = 32'h99;
    q_addr = 5'd5; #1;
    testsRun++; if (q_hit !== 1'b1 || q_data !== 32'h2) begin testsFailed++; $display("[TB] FAIL lookup_youngest got %b/%h want 1/2", q_hit, q_data); end
    q_addr = 5'd6; #1;
    testsRun++; if (q_hit !== 1'b0 || q_data !== 32'h0) begin testsFailed++; $display("[TB] FAIL lookup_miss got %b/%h want 0/0", q_hit, q_data); end
    q_addr = 5'd29; #1;
    testsRun++; if (q_hit !== 1'b1 || q_data !== 32'h2) begin testsFailed++; $display("[TB] FAIL lookup_upper_ignored got %b/%h want 1/2", q_hit, q_data); end
    wr_hold = 1'b0;
    tick();
    q_addr = 5'd5; #1;
    testsRun++; if (write !== 1'b1 || q_hit !== 1'b1 || q_data !== 32'h2) begin testsFailed++; $display("[TB] FAIL lookup_head_popping got write=%b hit=%b data=%h want 1/1/2", write, q_hit, q_data); end
    tick();
    testsRun++; if (q_hit !== 1'b0 || count !== 3'd0) begin testsFailed++; $display("[TB] FAIL lookup_after_drain got hit=%b count=%0d want 0/0", q_hit, count); end
  endtask

  task automatic test_back_to_back();
    wr_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_addr = AW'(i); in_data = 32'h100 + i;
      tick();
    end
    wr_hold = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j + 2 < 10) begin
        in_valid = 1'b1; in_addr = AW'(j + 2); in_data = 32'h100 + j + 2;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      testsRun++;
      if (write !== 1'b1 || waddr !== AW'(j) || wdata !== 32'h100 + j || count !== ((j < 9) ? 3'd2 : 3'd1)) begin
        testsFailed++;
        $display("[TB] FAIL stream_%0d got write=%b waddr=%0d wdata=%h count=%0d want 1/%0d/%h/%0d", j, write, waddr, wdata, count, j, 32'h100 + j, (j < 9) ? 2 : 1);
      end
      tick();
    end
    in_valid = 1'b0;
    testsRun++; if (count !== 3'd0 || write !== 1'b0) begin testsFailed++; $display("[TB] FAIL stream_end got count=%0d write=%b want 0/0", count, write); end
  endtask

  task automatic test_reset_flush();
    wr_hold = 1'b1;
    in_valid = 1'b1; in_addr = 5'd1; in_data = 32'hA; tick();
    in_valid = 1'b1; in_addr = 5'd2; in_data = 32'hB; tick();
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'hC; tick();
    testsRun++; if (count !== 3'd3) begin testsFailed++; $display("[TB] FAIL flush_prefill got count=%0d want 3", count); end
    reset = 1'b0; in_valid = 1'b1; in_addr = 5'd6; in_data = 32'h66;
    tick();
    reset = 1'b1; in_valid = 1'b0; wr_hold = 1'b0; q_addr = 5'd1;
    #1;
    testsRun++; if (count !== 3'd0 || write !== 1'b0 || q_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_state got count=%0d write=%b hit=%b want 0/0/0", count, write, q_hit); end
    q_addr = 5'd6; #1;
    testsRun++; if (q_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_push_ignored got hit=%b want 0", q_hit); end
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    #1;
    testsRun++; if (write !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h77 || count !== 3'd1) begin testsFailed++; $display("[TB] FAIL flush_new_write got %b/%0d/%h count=%0d want 1/7/77/1", write, waddr, wdata, count); end
    tick();
    testsRun++; if (count !== 3'd0 || write !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_final got count=%0d write=%b want 0/0", count, write); end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; wr_hold = 1'b0; q_addr = '0;
    test_reset();
    test_single_push();
    test_full_hold();
    test_lookup();
    test_back_to_back();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
